decode_stage: RTL and testbench

Parametrised RV32I/M instruction decode stage with a valid/ready handshake on both sides. It sits between the fetch stage and the register-read/execute stage. Each accepted instruction is turned into one registered control bundle. A two-entry skid buffer provides back-pressure in place of a global stall, and a flush input discards in-flight work on redirect.

---
 rtl/decode_stage_if.sv | 46 ++++
 rtl/decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Handshake bundles around the decode stage: fetch-side request and
// issue-side decoded control bundle.
interface decode_in_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_raw;
    logic [XLEN-1:0] pc_in;
    logic            flush;

    modport master (output in_valid, instr_raw, pc_in, flush, input in_ready);
    modport slave  (input in_valid, instr_raw, pc_in, flush, output in_ready);
endinterface

interface decode_out_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [4:0]      ctl;
    logic            src_imm;
    logic            src_pc;
    logic            read_reg1;
    logic            read_reg2;
    logic [4:0]      reg1_addr;
    logic [4:0]      reg2_addr;
    logic [4:0]      write_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic [XLEN-1:0] pc_out;

    modport master (output out_valid, imm, ctl, src_imm, src_pc, read_reg1, read_reg2,
                           reg1_addr, reg2_addr, write_reg, reg_write, mem_read, mem_write,
                           branch, jump, illegal, pc_out,
                    input  out_ready);
    modport slave  (input  out_valid, imm, ctl, src_imm, src_pc, read_reg1, read_reg2,
                           reg1_addr, reg2_addr, write_reg, reg_write, mem_read, mem_write,
                           branch, jump, illegal, pc_out,
                    output out_ready);
endinterface

// File: rtl/decode_stage.sv
// RV32I/M decode stage: combinational decode into a registered control bundle,
// backed by a one-entry skid register so back-pressure never needs a global stall.
module decode_stage #(
    parameter int XLEN          = 32,
    parameter bit ENABLE_M      = 1'b1,
    parameter bit ENABLE_BRANCH = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decode_in_if.slave    fetch_i,
    decode_out_if.master  issue_o
);
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [4:0]      ctl;
        logic            src_imm;
        logic            src_pc;
        logic            read_reg1;
        logic            read_reg2;
        logic [4:0]      reg1_addr;
        logic [4:0]      reg2_addr;
        logic [4:0]      write_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } bundle_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] CTL_AND  = 5'd0;
    localparam logic [4:0] CTL_OR   = 5'd1;
    localparam logic [4:0] CTL_ADD  = 5'd2;
    localparam logic [4:0] CTL_XOR  = 5'd3;
    localparam logic [4:0] CTL_SLL  = 5'd4;
    localparam logic [4:0] CTL_SRL  = 5'd5;
    localparam logic [4:0] CTL_SUB  = 5'd6;
    localparam logic [4:0] CTL_SLT  = 5'd7;
    localparam logic [4:0] CTL_LUI  = 5'd10;
    localparam logic [4:0] CTL_SLTU = 5'd13;
    localparam logic [4:0] CTL_SRA  = 5'd15;
    localparam logic [4:0] CTL_BEQ  = 5'd24;
    localparam logic [4:0] CTL_BNE  = 5'd25;
    localparam logic [4:0] CTL_BLT  = 5'd26;
    localparam logic [4:0] CTL_BGE  = 5'd27;
    localparam logic [4:0] CTL_BLTU = 5'd28;
    localparam logic [4:0] CTL_BGEU = 5'd29;
    localparam logic [4:0] CTL_ILL  = 5'd31;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic bundle_t reset_bundle();
        bundle_t b;
        b     = '0;
        b.ctl = CTL_ILL;
        return b;
    endfunction

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      funct6;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign instr  = fetch_i.instr_raw;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign funct6 = instr[31:26];

    assign imm_i = sext({{20{instr[31]}}, instr[31:20]});
    assign imm_s = sext({{20{instr[31]}}, instr[31:25], instr[11:7]});
    assign imm_b = sext({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
    assign imm_j = sext({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
    assign imm_u = sext({instr[31:12], 12'b0});

    bundle_t dec;
    logic    legal;
    logic    wr_en;

    always_comb begin
        dec           = '0;
        dec.ctl       = CTL_ILL;
        dec.src_imm   = 1'b1;
        dec.reg1_addr = instr[19:15];
        dec.reg2_addr = instr[24:20];
        dec.write_reg = instr[11:7];
        dec.pc        = fetch_i.pc_in;
        legal         = 1'b0;
        wr_en         = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal   = 1'b1;
                wr_en   = 1'b1;
                dec.ctl = CTL_LUI;
                dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                legal      = 1'b1;
                wr_en      = 1'b1;
                dec.ctl    = CTL_ADD;
                dec.imm    = imm_u;
                dec.src_pc = 1'b1;
            end
            OPC_JAL: begin
                legal      = ENABLE_BRANCH;
                wr_en      = 1'b1;
                dec.ctl    = CTL_ADD;
                dec.imm    = imm_j;
                dec.src_pc = 1'b1;
                dec.jump   = 1'b1;
            end
            OPC_JALR: begin
                legal         = ENABLE_BRANCH && (funct3 == 3'b000);
                wr_en         = 1'b1;
                dec.ctl       = CTL_ADD;
                dec.imm       = imm_i;
                dec.read_reg1 = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_BRANCH: begin
                legal         = ENABLE_BRANCH;
                dec.imm       = imm_b;
                dec.read_reg1 = 1'b1;
                dec.read_reg2 = 1'b1;
                dec.src_imm   = 1'b0;
                dec.branch    = 1'b1;
                case (funct3)
                    3'b000:  dec.ctl = CTL_BEQ;
                    3'b001:  dec.ctl = CTL_BNE;
                    3'b100:  dec.ctl = CTL_BLT;
                    3'b101:  dec.ctl = CTL_BGE;
                    3'b110:  dec.ctl = CTL_BLTU;
                    3'b111:  dec.ctl = CTL_BGEU;
                    default: legal   = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal         = (funct3 == 3'b010);
                wr_en         = 1'b1;
                dec.ctl       = CTL_ADD;
                dec.imm       = imm_i;
                dec.read_reg1 = 1'b1;
                dec.mem_read  = 1'b1;
            end
            OPC_STORE: begin
                legal         = (funct3 == 3'b010);
                dec.ctl       = CTL_ADD;
                dec.imm       = imm_s;
                dec.read_reg1 = 1'b1;
                dec.read_reg2 = 1'b1;
                dec.mem_write = 1'b1;
            end
            OPC_OPIMM: begin
                legal         = 1'b1;
                wr_en         = 1'b1;
                dec.imm       = imm_i;
                dec.read_reg1 = 1'b1;
                case (funct3)
                    3'b000: dec.ctl = CTL_ADD;
                    3'b010: dec.ctl = CTL_SLT;
                    3'b011: dec.ctl = CTL_SLTU;
                    3'b100: dec.ctl = CTL_XOR;
                    3'b110: dec.ctl = CTL_OR;
                    3'b111: dec.ctl = CTL_AND;
                    3'b001: begin
                        dec.ctl = CTL_SLL;
                        legal   = (funct6 == 6'b000000);
                    end
                    default: begin
                        dec.ctl = (funct6 == 6'b010000) ? CTL_SRA : CTL_SRL;
                        legal   = (funct6 == 6'b000000) || (funct6 == 6'b010000);
                    end
                endcase
            end
            OPC_OP: begin
                legal         = 1'b1;
                wr_en         = 1'b1;
                dec.read_reg1 = 1'b1;
                dec.read_reg2 = 1'b1;
                dec.src_imm   = 1'b0;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.ctl = CTL_ADD;
                        3'b001:  dec.ctl = CTL_SLL;
                        3'b010:  dec.ctl = CTL_SLT;
                        3'b011:  dec.ctl = CTL_SLTU;
                        3'b100:  dec.ctl = CTL_XOR;
                        3'b101:  dec.ctl = CTL_SRL;
                        3'b110:  dec.ctl = CTL_OR;
                        default: dec.ctl = CTL_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.ctl = CTL_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.ctl = CTL_SRA;
                end else if (ENABLE_M && funct7 == 7'b0000001) begin
                    // M-extension ops occupy codes 16..23 in funct3 order
                    dec.ctl = {2'b10, funct3};
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.ctl       = CTL_ILL;
            dec.imm       = '0;
            dec.src_imm   = 1'b1;
            dec.src_pc    = 1'b0;
            dec.read_reg1 = 1'b0;
            dec.read_reg2 = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.illegal   = 1'b1;
        end
        dec.reg_write = legal && wr_en && (instr[11:7] != 5'd0);
    end

    bundle_t main_q, main_d, skid_q, skid_d;
    logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic    in_fire, main_load;

    assign fetch_i.in_ready = ~skid_valid_q;
    assign in_fire   = fetch_i.in_valid & ~skid_valid_q & ~fetch_i.flush;
    assign main_load = ~main_valid_q | issue_o.out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (fetch_i.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_load) begin
            // A full skid entry blocks in_ready, so it never competes with a new input
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_d = dec;
                end
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= reset_bundle();
            main_valid_q <= 1'b0;
            skid_q       <= reset_bundle();
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign issue_o.out_valid = main_valid_q;
    assign issue_o.imm       = main_q.imm;
    assign issue_o.ctl       = main_q.ctl;
    assign issue_o.src_imm   = main_q.src_imm;
    assign issue_o.src_pc    = main_q.src_pc;
    assign issue_o.read_reg1 = main_q.read_reg1;
    assign issue_o.read_reg2 = main_q.read_reg2;
    assign issue_o.reg1_addr = main_q.reg1_addr;
    assign issue_o.reg2_addr = main_q.reg2_addr;
    assign issue_o.write_reg = main_q.write_reg;
    assign issue_o.reg_write = main_q.reg_write;
    assign issue_o.mem_read  = main_q.mem_read;
    assign issue_o.mem_write = main_q.mem_write;
    assign issue_o.branch    = main_q.branch;
    assign issue_o.jump      = main_q.jump;
    assign issue_o.illegal   = main_q.illegal;
    assign issue_o.pc_out    = main_q.pc;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of decode vectors plus hand-written
// stall, flush, async-reset and ENABLE_M=0 sequences.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_in_if  #(.XLEN(32)) in_a ();
    decode_out_if #(.XLEN(32)) out_a ();
    decode_in_if  #(.XLEN(32)) in_b ();
    decode_out_if #(.XLEN(32)) out_b ();

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_BRANCH(1'b1)) dut (
        .clk(clk), .rst(rst), .fetch_i(in_a), .issue_o(out_a));
    decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_BRANCH(1'b1)) dut_nom (
        .clk(clk), .rst(rst), .fetch_i(in_b), .issue_o(out_b));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  ctl;
        logic [31:0] imm;
        logic [9:0]  flags;   // {illegal, reg_write, rr1, rr2, src_imm, src_pc, mem_rd, mem_wr, branch, jump}
        logic [9:0]  mask;
    } vec_t;

    localparam logic [9:0] ALL = 10'h3FF;
    localparam logic [9:0] ILM = 10'b1100001111;
    localparam logic [9:0] ILF = 10'b1000000000;
    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] flags_a();
        return {out_a.illegal, out_a.reg_write, out_a.read_reg1, out_a.read_reg2, out_a.src_imm,
                out_a.src_pc, out_a.mem_read, out_a.mem_write, out_a.branch, out_a.jump};
    endfunction

    task automatic drive_a(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_a.in_valid  = v;
        in_a.instr_raw = ins;
        in_a.pc_in     = pc;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 5'd2,  32'h00000005, 10'b0110100000, ALL};
        vecs[1]  = '{32'hFFF00193, 5'd2,  32'hFFFFFFFF, 10'b0110100000, ALL};
        vecs[2]  = '{32'hFE0008E3, 5'd24, 32'hFFFFFFF0, 10'b0011000010, ALL};
        vecs[3]  = '{32'h008000EF, 5'd2,  32'h00000008, 10'b0100110001, ALL};
        vecs[4]  = '{32'h40208133, 5'd6,  32'h00000000, 10'b0111000000, ALL};
        vecs[5]  = '{32'h0000A103, 5'd2,  32'h00000000, 10'b0110101000, ALL};
        vecs[6]  = '{32'h00112023, 5'd2,  32'h00000000, 10'b0011100100, ALL};
        vecs[7]  = '{32'hFE112E23, 5'd2,  32'hFFFFFFFC, 10'b0011100100, ALL};
        vecs[8]  = '{32'h123450B7, 5'd10, 32'h12345000, 10'b0100100000, ALL};
        vecs[9]  = '{32'hFFFFF117, 5'd2,  32'hFFFFF000, 10'b0100110000, ALL};
        vecs[10] = '{32'h000080E7, 5'd2,  32'h00000000, 10'b0110100001, ALL};
        vecs[11] = '{32'h4030D093, 5'd15, 32'h00000403, 10'b0110100000, ALL};
        vecs[12] = '{32'h02208133, 5'd16, 32'h00000000, 10'b0111000000, ALL};
        vecs[13] = '{32'h0220D133, 5'd21, 32'h00000000, 10'b0111000000, ALL};
        vecs[14] = '{32'h00000013, 5'd2,  32'h00000000, 10'b0010100000, ALL};
        vecs[15] = '{32'h80109093, 5'd31, 32'h00000000, ILF, ILM};
        vecs[16] = '{32'h10208133, 5'd31, 32'h00000000, ILF, ILM};
        vecs[17] = '{32'h0000007F, 5'd31, 32'h00000000, ILF, ILM};

        drive_a(1'b0, 32'h0, 32'h0);
        in_a.flush      = 1'b0;
        out_a.out_ready = 1'b1;
        in_b.in_valid   = 1'b0;
        in_b.instr_raw  = 32'h0;
        in_b.pc_in      = 32'h0;
        in_b.flush      = 1'b0;
        out_b.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_a.out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_a.in_ready),   64'd1);
        chk("rst_ctl",       64'(out_a.ctl),       64'd31);
        chk("rst_imm",       64'(out_a.imm),       64'd0);
        chk("rst_flags",     64'(flags_a()),       64'd0);
        chk("rst_pc",        64'(out_a.pc_out),    64'd0);
        rst = 1'b0;
        tick();

        // Table-driven decode at full throughput
        for (int i = 0; i < 18; i++) begin
            logic [31:0] iv;
            logic [31:0] pcv;
            iv  = vecs[i].instr;
            pcv = 32'h1000 + 32'(4 * i);
            drive_a(1'b1, iv, pcv);
            tick();
            $display("vec %0d instr %08h -> valid %0d ctl %0d imm %08h flags %010b",
                     i, iv, out_a.out_valid, out_a.ctl, out_a.imm, flags_a());
            chk("vec_valid", 64'(out_a.out_valid), 64'd1);
            chk("vec_ctl",   64'(out_a.ctl),       64'(vecs[i].ctl));
            chk("vec_imm",   64'(out_a.imm),       64'(vecs[i].imm));
            chk("vec_flags", 64'(flags_a() & vecs[i].mask), 64'(vecs[i].flags));
            chk("vec_regs",  64'({out_a.reg1_addr, out_a.reg2_addr, out_a.write_reg}),
                             64'({iv[19:15], iv[24:20], iv[11:7]}));
            chk("vec_pc",    64'(out_a.pc_out),    64'(pcv));
        end
        drive_a(1'b0, 32'h0, 32'h0);
        tick();
        chk("drain_valid", 64'(out_a.out_valid), 64'd0);

        // Back-pressure: sub, lw, sw with out_ready low for three cycles
        out_a.out_ready = 1'b0;
        drive_a(1'b1, 32'h40208133, 32'h2000);
        tick();
        $display("stall: accept sub, in_ready %0d", in_a.in_ready);
        chk("stall1_valid", 64'(out_a.out_valid), 64'd1);
        chk("stall1_ctl",   64'(out_a.ctl),       64'd6);
        chk("stall1_ready", 64'(in_a.in_ready),   64'd1);
        drive_a(1'b1, 32'h0000A103, 32'h2004);
        tick();
        $display("stall: accept lw into skid, in_ready %0d", in_a.in_ready);
        chk("stall2_ready", 64'(in_a.in_ready),   64'd0);
        chk("stall2_ctl",   64'(out_a.ctl),       64'd6);
        chk("stall2_pc",    64'(out_a.pc_out),    64'h2000);
        drive_a(1'b1, 32'h00112023, 32'h2008);
        tick();
        $display("stall: sw blocked, in_ready %0d", in_a.in_ready);
        chk("stall3_ready", 64'(in_a.in_ready),   64'd0);
        chk("stall3_ctl",   64'(out_a.ctl),       64'd6);
        chk("stall3_pc",    64'(out_a.pc_out),    64'h2000);
        chk("stall3_rd",    64'(out_a.write_reg), 64'd2);
        out_a.out_ready = 1'b1;
        tick();
        $display("stall: release, pc %08h", out_a.pc_out);
        chk("rel1_pc",    64'(out_a.pc_out),   64'h2004);
        chk("rel1_mrd",   64'(out_a.mem_read), 64'd1);
        chk("rel1_ready", 64'(in_a.in_ready),  64'd1);
        tick();
        $display("stall: release, pc %08h", out_a.pc_out);
        chk("rel2_pc",    64'(out_a.pc_out),    64'h2008);
        chk("rel2_mwr",   64'(out_a.mem_write), 64'd1);
        chk("rel2_valid", 64'(out_a.out_valid), 64'd1);
        drive_a(1'b0, 32'h0, 32'h0);
        tick();
        chk("rel3_valid", 64'(out_a.out_valid), 64'd0);

        // Flush with both entries full
        out_a.out_ready = 1'b0;
        drive_a(1'b1, 32'h00500093, 32'h3000);
        tick();
        drive_a(1'b1, 32'h123450B7, 32'h3004);
        tick();
        chk("fl_full_ready", 64'(in_a.in_ready), 64'd0);
        drive_a(1'b1, 32'h008000EF, 32'h3008);
        in_a.flush = 1'b1;
        tick();
        $display("flush: valid %0d in_ready %0d", out_a.out_valid, in_a.in_ready);
        chk("fl_valid", 64'(out_a.out_valid), 64'd0);
        chk("fl_ready", 64'(in_a.in_ready),   64'd1);
        in_a.flush = 1'b0;
        drive_a(1'b0, 32'h0, 32'h0);
        out_a.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("fl_after_valid", 64'(out_a.out_valid), 64'd0);
        end

        // Flush with only main full drops a presentable input
        out_a.out_ready = 1'b0;
        drive_a(1'b1, 32'h00500093, 32'h3100);
        tick();
        drive_a(1'b1, 32'h008000EF, 32'h3104);
        in_a.flush = 1'b1;
        tick();
        in_a.flush = 1'b0;
        drive_a(1'b0, 32'h0, 32'h0);
        chk("fl2_valid", 64'(out_a.out_valid), 64'd0);
        out_a.out_ready = 1'b1;
        tick();
        chk("fl2_after_valid", 64'(out_a.out_valid), 64'd0);

        // Asynchronous reset between edges
        out_a.out_ready = 1'b0;
        drive_a(1'b1, 32'h00500093, 32'h4000);
        tick();
        drive_a(1'b0, 32'h0, 32'h0);
        chk("ar_pre_valid", 64'(out_a.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        $display("async reset: valid %0d ctl %0d", out_a.out_valid, out_a.ctl);
        chk("ar_valid", 64'(out_a.out_valid), 64'd0);
        chk("ar_ctl",   64'(out_a.ctl),       64'd31);
        #2;
        rst = 1'b0;
        out_a.out_ready = 1'b1;
        tick();
        chk("ar_post_valid", 64'(out_a.out_valid), 64'd0);

        // ENABLE_M = 0 instance
        in_b.in_valid  = 1'b1;
        in_b.instr_raw = 32'h02208133;
        in_b.pc_in     = 32'h5000;
        tick();
        $display("nom: mul -> valid %0d illegal %0d ctl %0d", out_b.out_valid, out_b.illegal, out_b.ctl);
        chk("nom_mul_valid", 64'(out_b.out_valid), 64'd1);
        chk("nom_mul_ill",   64'(out_b.illegal),   64'd1);
        chk("nom_mul_ctl",   64'(out_b.ctl),       64'd31);
        chk("nom_mul_rw",    64'(out_b.reg_write), 64'd0);
        in_b.instr_raw = 32'h40208133;
        in_b.pc_in     = 32'h5004;
        tick();
        $display("nom: sub -> illegal %0d ctl %0d", out_b.illegal, out_b.ctl);
        chk("nom_sub_ill", 64'(out_b.illegal), 64'd0);
        chk("nom_sub_ctl", 64'(out_b.ctl),     64'd6);
        in_b.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
